// File: rtl/seq_addsub.sv
// seq_addsub: digit-serial adder/subtractor with valid/ready handshakes.
//   Accepts a, b, sub in IDLE, then spends NDIG = WIDTH/DIGIT cycles in RUN
//   adding DIGIT bits per cycle (LSB first), then presents result and flags
//   in DONE until the sink takes them.
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   DIGIT  bits per cycle, must divide WIDTH
// Ports:
//   clk, rst (sync, active high)
//   in_valid/in_ready, a, b, sub   operand handshake (sub=1 -> a-b)
//   out_valid/out_ready            result handshake
//   result, cout, ovf, zero        sum/difference and flags
// Build option:
//   SEQ_ADDSUB_SATURATE_EN  clamp result to the signed limit on overflow
//                           (ovf/cout still report the raw flags)
module seq_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] opa, opb, acc, acc_nxt, fin;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dsum;
  logic             cin_msb, ovf_raw, last;

  // Digit adder and the value the result register takes on this step.
  always_comb begin
    dsum    = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    acc_nxt = acc >> DIGIT;
    acc_nxt[WIDTH-1 -: DIGIT] = dsum[DIGIT-1:0];
    // Carry into the digit's top bit recovered from sum bit = a ^ b ^ cin.
    cin_msb = dsum[DIGIT-1] ^ opa[DIGIT-1] ^ opb[DIGIT-1];
    ovf_raw = cin_msb ^ dsum[DIGIT];
    last    = (cnt == CW'(NDIG - 1));
    fin     = acc_nxt;
`ifdef SEQ_ADDSUB_SATURATE_EN
    // On overflow both operand MSBs agree, so A's MSB gives the direction.
    if (ovf_raw)
      fin = opa[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. Output registers load only on the final digit, so a reset or
  // an in-flight operation never exposes a partial sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          opa   <= a;
          opb   <= b ^ {WIDTH{sub}};
          carry <= sub;
          cnt   <= '0;
        end
        RUN: begin
          opa   <= opa >> DIGIT;
          opb   <= opb >> DIGIT;
          acc   <= acc_nxt;
          carry <= dsum[DIGIT];
          cnt   <= cnt + 1'b1;
          if (last) begin
            result <= fin;
            cout   <= dsum[DIGIT];
            ovf    <= ovf_raw;
            zero   <= (fin == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_addsub.sv
// Directed bench for seq_addsub: a WIDTH=4/DIGIT=1 instance driven from a
// vector table plus handshake/backpressure/reset sequences, and a
// WIDTH=8/DIGIT=2 instance for the wider-digit latency case.
module tb_seq_addsub;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-bit, 1 bit per cycle
  logic       iv4, ir4, sub4, ov4, or4, co4, of4, z4;
  logic [3:0] a4, b4, r4;
  // 8-bit, 2 bits per cycle
  logic       iv8, ir8, sub8, ov8, or8, co8, of8, z8;
  logic [7:0] a8, b8, r8;

  seq_addsub #(.WIDTH(4), .DIGIT(1)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .sub(sub4),
    .out_valid(ov4), .out_ready(or4), .result(r4), .cout(co4), .ovf(of4), .zero(z4));
  seq_addsub #(.WIDTH(8), .DIGIT(2)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .sub(sub8),
    .out_valid(ov8), .out_ready(or8), .result(r8), .cout(co8), .ovf(of8), .zero(z8));

`ifdef SEQ_ADDSUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] a, b;
    logic       sub;
    logic [3:0] res, res_sat;
    logic       cout, ovf, zero;
  } vec_t;

  // Run one op on the selected instance; returns outputs and the number of
  // cycles from accepting edge to out_valid (-1 on timeout).
  task automatic run_op(input bit wide, input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [7:0] res, output logic co, output logic of,
                        output logic z, output int lat);
    int n;
    bit busy_ok;
    lat = -1; busy_ok = 1'b1;
    res = '0; co = 1'b0; of = 1'b0; z = 1'b0;
    n = 0;
    while (!(wide ? ir8 : ir4) && n < 50) begin @(posedge clk); #1; n++; end
    if (wide) begin iv8 = 1'b1; a8 = a; b8 = b; sub8 = s; end
    else      begin iv4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; sub4 = s; end
    @(posedge clk); #1;
    iv4 = 1'b0; iv8 = 1'b0;
    // scramble inputs: they must not matter after acceptance
    a4 = ~a4; b4 = ~b4; a8 = ~a8; b8 = ~b8;
    for (int c = 1; c <= 50; c++) begin
      if (wide ? ir8 : ir4) busy_ok = 1'b0;
      if (wide ? ov8 : ov4) begin lat = c - 1; break; end
      @(posedge clk); #1;
    end
    chk("in_ready_low_while_busy", busy_ok, 1'b1);
    if (lat < 0) begin
      failures++;
      $display("FAIL out_valid_timeout: got none expected within 50 cycles");
      return;
    end
    if (wide) begin res = r8; co = co8; of = of8; z = z8; end
    else      begin res = {4'b0, r4}; co = co4; of = of4; z = z4; end
    or4 = 1'b1; or8 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0; or8 = 1'b0;
    chk("in_ready_after_pop", wide ? ir8 : ir4, 1'b1);
  endtask

  vec_t vt [9];
  logic [7:0] res;
  logic co, of, z;
  int lat;
  logic [3:0] hold_r;
  logic hold_c, hold_o, hold_z;

  initial begin
    vt[0] = '{4'b1010, 4'b1011, 1'b0, 4'b0101, 4'b1000, 1'b1, 1'b1, 1'b0};
    vt[1] = '{4'b1010, 4'b1011, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0};
    vt[2] = '{4'b0101, 4'b0101, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1};
    vt[3] = '{4'b0110, 4'b0100, 1'b0, 4'b1010, 4'b0111, 1'b0, 1'b1, 1'b0};
    vt[4] = '{4'b0110, 4'b0100, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0};
    vt[5] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1};
    vt[6] = '{4'b0111, 4'b1000, 1'b1, 4'b1111, 4'b0111, 1'b0, 1'b1, 1'b0};
    vt[7] = '{4'b1000, 4'b0001, 1'b1, 4'b0111, 4'b1000, 1'b1, 1'b1, 1'b0};
    vt[8] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    iv4 = 0; a4 = 0; b4 = 0; sub4 = 0; or4 = 0;
    iv8 = 0; a8 = 0; b8 = 0; sub8 = 0; or8 = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_in_ready", ir4, 1'b1);
    chk("reset_out_valid", ov4, 1'b0);
    chk("reset_result", {r4, co4, of4, z4}, 7'b0);

    // Table-driven vectors on the 4-bit instance
    for (int i = 0; i < 9; i++) begin
      run_op(1'b0, {4'b0, vt[i].a}, {4'b0, vt[i].b}, vt[i].sub, res, co, of, z, lat);
      chk($sformatf("v%0d_latency", i), lat, 4);
      chk($sformatf("v%0d_result", i), res, {4'b0, SAT ? vt[i].res_sat : vt[i].res});
      chk($sformatf("v%0d_cout", i), co, vt[i].cout);
      chk($sformatf("v%0d_ovf", i), of, vt[i].ovf);
      chk($sformatf("v%0d_zero", i), z, vt[i].zero);
    end

    // Wider digit: 0x7F + 0x01 and 0xFF - 0x01
    run_op(1'b1, 8'h7F, 8'h01, 1'b0, res, co, of, z, lat);
    chk("w8_add_latency", lat, 4);
    chk("w8_add_result", res, SAT ? 8'h7F : 8'h80);
    chk("w8_add_ovf", of, 1'b1);
    chk("w8_add_cout", co, 1'b0);
    run_op(1'b1, 8'hFF, 8'h01, 1'b1, res, co, of, z, lat);
    chk("w8_sub_result", res, 8'hFE);
    chk("w8_sub_cout", co, 1'b1);
    chk("w8_sub_ovf", of, 1'b0);

    // Backpressure: 0011 + 0001 held in DONE for 10 cycles
    iv4 = 1'b1; a4 = 4'b0011; b4 = 4'b0001; sub4 = 1'b0;
    @(posedge clk); #1;
    iv4 = 1'b0;
    for (int c = 0; c < 4; c++) begin @(posedge clk); #1; end
    chk("bp_out_valid", ov4, 1'b1);
    chk("bp_result", r4, 4'b0100);
    hold_r = r4; hold_c = co4; hold_o = of4; hold_z = z4;
    iv4 = 1'b1; a4 = 4'b1111; b4 = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_stable", {ov4, ir4, r4, co4, of4, z4}, {1'b1, 1'b0, hold_r, hold_c, hold_o, hold_z});
    end
    or4 = 1'b1;  // in_valid still high on this edge: must be ignored
    @(posedge clk); #1;
    or4 = 1'b0; iv4 = 1'b0;
    chk("bp_release_in_ready", ir4, 1'b1);
    chk("bp_release_out_valid", ov4, 1'b0);
    @(posedge clk); #1;
    chk("bp_not_consumed", {ir4, ov4}, 2'b10);

    // Reset in the middle of RUN
    iv4 = 1'b1; a4 = 4'b0110; b4 = 4'b0001; sub4 = 1'b0;
    @(posedge clk); #1;
    iv4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_out_valid", ov4, 1'b0);
    chk("rst_mid_in_ready", ir4, 1'b1);
    chk("rst_mid_result", r4, 4'b0000);
    run_op(1'b0, 8'h02, 8'h03, 1'b0, res, co, of, z, lat);
    chk("after_rst_latency", lat, 4);
    chk("after_rst_result", res, 8'h05);
    chk("after_rst_flags", {co, of, z}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
